// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the register-dump FSM state encoding.
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready holding register: a load refills the slot on the same
// edge a beat is accepted, so back-to-back beats stream at one per cycle.
module stream_out_reg #(
  parameter int W = 37
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         free_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks every architectural register through one read port and streams
// (address, data) beats over valid/ready, pulsing done after the last accept.
module regfile_dump_reader
  import cpu_pkg::*;
#(
  parameter int NUM_REGS  = cpu_pkg::NUM_REGS,
  parameter int ADDR_W    = cpu_pkg::REG_ADDR_W,
  parameter int DATA_W    = cpu_pkg::DATA_W,
  parameter int SKIP_ZERO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  // One extra index bit so the final index never aliases back to zero.
  localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W + 1)'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] FIRST_IDX = (SKIP_ZERO != 0) ? (ADDR_W + 1)'(1) : '0;

  dump_state_t       state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic              load;
  logic              slot_free;
  logic [ADDR_W-1:0] rd_addr_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    load      = 1'b0;
    rd_addr_d = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          idx_d   = FIRST_IDX;
        end
      end
      SCAN: begin
        rd_addr_d = idx_q[ADDR_W-1:0];
        if (slot_free) begin
          load  = 1'b1;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  stream_out_reg #(
    .W(ADDR_W + DATA_W)
  ) u_out (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (load),
    .data_i ({rd_addr_d, rd_data}),
    .ready_i(out_ready),
    .valid_o(out_valid),
    .data_o ({out_addr, out_data}),
    .free_o (slot_free)
  );

  assign rd_addr = rd_addr_d;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule
